// File: rtl/ram_rd_chk.sv
// ram_rd_chk: readback checker for the RAM write/read pattern generator.
// Snoops the generator's accesses and keeps a shadow copy of every written
// word. Each RAM read return is compared against the shadow copy RD_LAT
// cycles after the read was issued. Reports per-read results, saturating
// pass/error counters and a per-round verdict.
// Optional feature: define RAM_CHK_FIRST_ERR_EN to add first-mismatch
// capture outputs (first_err_addr/exp/act/vld).
module ram_rd_chk #(
    parameter int RD_LAT = 1,   // RAM read latency, legal 1..3
    parameter int CNT_W  = 16   // width of err_cnt, pass_cnt, round_cnt
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ram_en,
    input  logic             rw,
    input  logic [4:0]       ram_addr,
    input  logic [7:0]       ram_wr_data,
    input  logic [7:0]       ram_rd_data,
    output logic             chk_valid,
    output logic             chk_skip,
    output logic             chk_err,
    output logic [4:0]       chk_addr,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic             round_done,
    output logic             round_ok,
    output logic [CNT_W-1:0] round_cnt
`ifdef RAM_CHK_FIRST_ERR_EN
    ,
    output logic [4:0]       first_err_addr,
    output logic [7:0]       first_err_exp,
    output logic [7:0]       first_err_act,
    output logic             first_err_vld
`endif
);

    // Round-tracking FSM encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR    = 2'd1;
    localparam logic [1:0] S_RD    = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // DRAIN lasts RD_LAT+1 cycles: counter runs 0..RD_LAT
    localparam logic [1:0]       DRAIN_LAST = 2'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Error and pass counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Round counter wraps naturally
    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
        return v + CNT_ONE;
    endfunction

    // Access decode; rw makes read and write mutually exclusive
    logic wr_acc;
    logic rd_acc;

    assign wr_acc = ram_en & rw;
    assign rd_acc = ram_en & ~rw;

    // ---------------------------------------------------------------
    // Shadow storage
    // ---------------------------------------------------------------
    logic [7:0]  shadow_q [32];
    logic [31:0] mask_q;

    // Shadow data: contents only meaningful where the mask bit is set
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            shadow_q[ram_addr] <= ram_wr_data;
        end
    end

    // Written mask: marks addresses holding a valid shadow value
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (wr_acc) begin
            mask_q[ram_addr] <= 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Stage p0..p(RD_LAT-1): read-tag delay line matching RAM latency.
    // Newest entry at index 0, oldest (compare tap) at RD_LAT-1.
    // ---------------------------------------------------------------
    logic [RD_LAT-1:0]      rd_vld_q;
    logic [RD_LAT-1:0][4:0] rd_addr_q;
    logic [RD_LAT-1:0][7:0] rd_exp_q;
    logic [RD_LAT-1:0]      rd_wrt_q;

    // Valid chain: cleared on reset so in-flight reads are discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q <= '0;
        end else begin
            rd_vld_q <= RD_LAT'({rd_vld_q, rd_acc});
        end
    end

    // Payload chain: address, expected byte and written flag follow the valid
    always_ff @(posedge clk) begin
        rd_addr_q <= (RD_LAT*5)'({rd_addr_q, ram_addr});
        rd_exp_q  <= (RD_LAT*8)'({rd_exp_q, shadow_q[ram_addr]});
        rd_wrt_q  <= RD_LAT'({rd_wrt_q, mask_q[ram_addr]});
    end

    // ---------------------------------------------------------------
    // Compare stage: RAM data for the oldest tag is on ram_rd_data now
    // ---------------------------------------------------------------
    logic       cmp_vld;
    logic       cmp_wrt;
    logic [4:0] cmp_addr;
    logic [7:0] cmp_exp;
    logic       cmp_hit;
    logic       cmp_miss;

    assign cmp_vld  = rd_vld_q[RD_LAT-1];
    assign cmp_wrt  = rd_wrt_q[RD_LAT-1];
    assign cmp_addr = rd_addr_q[RD_LAT-1];
    assign cmp_exp  = rd_exp_q[RD_LAT-1];
    assign cmp_hit  = cmp_vld & cmp_wrt & (cmp_exp == ram_rd_data);
    assign cmp_miss = cmp_vld & cmp_wrt & (cmp_exp != ram_rd_data);

    // ---------------------------------------------------------------
    // Result stage: registered per-read outputs and counters
    // ---------------------------------------------------------------
    logic             chk_valid_q;
    logic             chk_skip_q;
    logic             chk_err_q;
    logic [4:0]       chk_addr_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] pass_cnt_q;

    // Present one result per completed read; skipped reads leave counters alone
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_valid_q <= 1'b0;
            chk_skip_q  <= 1'b0;
            chk_err_q   <= 1'b0;
            chk_addr_q  <= 5'd0;
            err_cnt_q   <= '0;
            pass_cnt_q  <= '0;
        end else begin
            chk_valid_q <= cmp_vld;
            chk_skip_q  <= cmp_vld & ~cmp_wrt;
            chk_err_q   <= cmp_miss;
            chk_addr_q  <= cmp_vld ? cmp_addr : 5'd0;
            if (cmp_hit) begin
                pass_cnt_q <= sat_inc(pass_cnt_q);
            end
            if (cmp_miss) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
        end
    end

    // ---------------------------------------------------------------
    // Round tracking FSM
    // ---------------------------------------------------------------
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [1:0]       drain_cnt_q;
    logic [1:0]       drain_cnt_d;
    logic             round_end;
    logic             rnd_err_q;
    logic             rnd_err_d;
    logic             round_done_q;
    logic             round_ok_q;
    logic [CNT_W-1:0] round_cnt_q;

    // Next-state logic: a round ends once the read phase has fully drained
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        round_end   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_acc) begin
                    state_d = S_WR;
                end else if (rd_acc) begin
                    state_d = S_RD;
                end
            end
            S_WR: begin
                if (rd_acc) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                // A write or an idle cycle closes the read phase
                if (!rd_acc) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 2'd0;
                end
            end
            S_DRAIN: begin
                // A new read resumes the same round; otherwise wait for
                // the last in-flight result to be counted
                if (rd_acc) begin
                    state_d = S_RD;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d   = S_WR;
                    round_end = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Round error flag: cleared at round end, set by any mismatch
    always_comb begin
        rnd_err_d = round_end ? 1'b0 : rnd_err_q;
        if (cmp_miss) begin
            rnd_err_d = 1'b1;
        end
    end

    // FSM state, drain counter and round flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= 2'd0;
            rnd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            rnd_err_q   <= rnd_err_d;
        end
    end

    // Round verdict outputs: pulse with the round end, count completed rounds
    always_ff @(posedge clk) begin
        if (rst) begin
            round_done_q <= 1'b0;
            round_ok_q   <= 1'b0;
            round_cnt_q  <= '0;
        end else begin
            round_done_q <= round_end;
            round_ok_q   <= round_end & ~rnd_err_q;
            if (round_end) begin
                round_cnt_q <= wrap_inc(round_cnt_q);
            end
        end
    end

`ifdef RAM_CHK_FIRST_ERR_EN
    // ---------------------------------------------------------------
    // First-mismatch capture
    // ---------------------------------------------------------------
    logic [4:0] fe_addr_q;
    logic [7:0] fe_exp_q;
    logic [7:0] fe_act_q;
    logic       fe_vld_q;

    // Latch the first mismatch after reset and hold it until the next reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fe_addr_q <= 5'd0;
            fe_exp_q  <= 8'd0;
            fe_act_q  <= 8'd0;
            fe_vld_q  <= 1'b0;
        end else if (cmp_miss && !fe_vld_q) begin
            fe_addr_q <= cmp_addr;
            fe_exp_q  <= cmp_exp;
            fe_act_q  <= ram_rd_data;
            fe_vld_q  <= 1'b1;
        end
    end

    assign first_err_addr = fe_addr_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_act  = fe_act_q;
    assign first_err_vld  = fe_vld_q;
`endif

    assign chk_valid  = chk_valid_q;
    assign chk_skip   = chk_skip_q;
    assign chk_err    = chk_err_q;
    assign chk_addr   = chk_addr_q;
    assign err_cnt    = err_cnt_q;
    assign pass_cnt   = pass_cnt_q;
    assign round_done = round_done_q;
    assign round_ok   = round_ok_q;
    assign round_cnt  = round_cnt_q;

endmodule

// File: tb/tb_ram_rd_chk.sv
// Directed bench for ram_rd_chk: three instances share one access stream
// (RD_LAT=1/CNT_W=16, RD_LAT=3/CNT_W=16, RD_LAT=1/CNT_W=4), each fed by a
// RAM model with the matching read latency.
module tb_ram_rd_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       rw;
    logic [4:0] addr;
    logic [7:0] wd;

    // RAM model with optional corruption of returned data
    logic [7:0] mem [32];
    logic       corrupt_en;
    logic       corrupt_all;
    logic [4:0] corrupt_addr;
    logic [7:0] rd_val;
    logic [7:0] p1, p2, p3;
    logic [7:0] rd1, rd3;

    always_comb begin
        rd_val = mem[addr];
        if (corrupt_all || (corrupt_en && addr == corrupt_addr)) rd_val = 8'hFF;
    end

    always @(posedge clk) begin
        if (en && rw) mem[addr] <= wd;
        p1 <= rd_val;
        p2 <= p1;
        p3 <= p2;
    end

    assign rd1 = p1;
    assign rd3 = p3;

    // DUT outputs
    logic        l1_valid, l1_skip, l1_err, l1_rdone, l1_rok;
    logic [4:0]  l1_addr;
    logic [15:0] l1_errc, l1_pass, l1_rcnt;
    logic        l3_valid, l3_skip, l3_err, l3_rdone, l3_rok;
    logic [4:0]  l3_addr;
    logic [15:0] l3_errc, l3_pass, l3_rcnt;
    logic        c4_valid, c4_skip, c4_err, c4_rdone, c4_rok;
    logic [4:0]  c4_addr;
    logic [3:0]  c4_errc, c4_pass, c4_rcnt;
`ifdef RAM_CHK_FIRST_ERR_EN
    logic [4:0]  l1_fe_addr, l3_fe_addr, c4_fe_addr;
    logic [7:0]  l1_fe_exp, l3_fe_exp, c4_fe_exp;
    logic [7:0]  l1_fe_act, l3_fe_act, c4_fe_act;
    logic        l1_fe_vld, l3_fe_vld, c4_fe_vld;
`endif

    ram_rd_chk #(.RD_LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .rst(rst), .ram_en(en), .rw(rw), .ram_addr(addr),
        .ram_wr_data(wd), .ram_rd_data(rd1),
        .chk_valid(l1_valid), .chk_skip(l1_skip), .chk_err(l1_err),
        .chk_addr(l1_addr), .err_cnt(l1_errc), .pass_cnt(l1_pass),
        .round_done(l1_rdone), .round_ok(l1_rok), .round_cnt(l1_rcnt)
`ifdef RAM_CHK_FIRST_ERR_EN
        , .first_err_addr(l1_fe_addr), .first_err_exp(l1_fe_exp),
        .first_err_act(l1_fe_act), .first_err_vld(l1_fe_vld)
`endif
    );

    ram_rd_chk #(.RD_LAT(3), .CNT_W(16)) u_l3 (
        .clk(clk), .rst(rst), .ram_en(en), .rw(rw), .ram_addr(addr),
        .ram_wr_data(wd), .ram_rd_data(rd3),
        .chk_valid(l3_valid), .chk_skip(l3_skip), .chk_err(l3_err),
        .chk_addr(l3_addr), .err_cnt(l3_errc), .pass_cnt(l3_pass),
        .round_done(l3_rdone), .round_ok(l3_rok), .round_cnt(l3_rcnt)
`ifdef RAM_CHK_FIRST_ERR_EN
        , .first_err_addr(l3_fe_addr), .first_err_exp(l3_fe_exp),
        .first_err_act(l3_fe_act), .first_err_vld(l3_fe_vld)
`endif
    );

    ram_rd_chk #(.RD_LAT(1), .CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .ram_en(en), .rw(rw), .ram_addr(addr),
        .ram_wr_data(wd), .ram_rd_data(rd1),
        .chk_valid(c4_valid), .chk_skip(c4_skip), .chk_err(c4_err),
        .chk_addr(c4_addr), .err_cnt(c4_errc), .pass_cnt(c4_pass),
        .round_done(c4_rdone), .round_ok(c4_rok), .round_cnt(c4_rcnt)
`ifdef RAM_CHK_FIRST_ERR_EN
        , .first_err_addr(c4_fe_addr), .first_err_exp(c4_fe_exp),
        .first_err_act(c4_fe_act), .first_err_vld(c4_fe_vld)
`endif
    );

    int n_vec;
    int n_fail;
    int cyc_n;
    int n1_v, n1_s, n1_e, n1_rd, t_v1, t_rd1;
    int n3_v, n3_rd, t_v3, t_rd3;
    logic       ok1, ok3;
    logic [4:0] err_addr1;
    int rd_last;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr();
        n1_v = 0; n1_s = 0; n1_e = 0; n1_rd = 0; t_v1 = -1; t_rd1 = -1;
        n3_v = 0; n3_rd = 0; t_v3 = -1; t_rd3 = -1;
        ok1 = 1'b0; ok3 = 1'b0; err_addr1 = 5'd0;
    endtask

    // Apply one cycle of stimulus, then sample outputs 1 time unit after the edge
    task automatic cyc(input logic e, input logic w, input logic [4:0] a, input logic [7:0] d);
        en = e; rw = w; addr = a; wd = d;
        @(posedge clk);
        #1;
        cyc_n++;
        if (l1_valid) begin
            n1_v++;
            t_v1 = cyc_n;
            if (l1_skip) n1_s++;
            if (l1_err) begin
                n1_e++;
                err_addr1 = l1_addr;
            end
        end
        if (l1_rdone) begin
            n1_rd++;
            t_rd1 = cyc_n;
            ok1 = l1_rok;
        end
        if (l3_valid) begin
            n3_v++;
            t_v3 = cyc_n;
        end
        if (l3_rdone) begin
            n3_rd++;
            t_rd3 = cyc_n;
            ok3 = l3_rok;
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 5'd0, 8'd0);
        rst = 1'b0;
        clr();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 5'd0, 8'd0);
    endtask

    initial begin
        n_vec = 0; n_fail = 0; cyc_n = 0;
        rst = 1'b1; en = 1'b0; rw = 1'b0; addr = 5'd0; wd = 8'd0;
        corrupt_en = 1'b0; corrupt_all = 1'b0; corrupt_addr = 5'd0;
        clr();

        // Reset state
        cyc(1'b0, 1'b0, 5'd0, 8'd0);
        cyc(1'b0, 1'b0, 5'd0, 8'd0);
        check("rst_flags", 32'({l1_valid, l1_skip, l1_err, l1_addr, l1_rdone, l1_rok}), 32'd0);
        check("rst_err_cnt", 32'(l1_errc), 32'd0);
        check("rst_pass_cnt", 32'(l1_pass), 32'd0);
        check("rst_round_cnt", 32'(l1_rcnt), 32'd0);
        rst = 1'b0;
        clr();

        // Clean round: write 0x01..0x20, read back
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 5'(i), 8'(i + 1));
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 1'b0, 5'(i), 8'd0);
            if (i == 0) check("l1_lat_early", 32'(l1_valid), 32'd0);
            if (i == 1) check("l1_lat_first", 32'({l1_valid, l1_addr}), 32'({1'b1, 5'd0}));
            if (i == 2) check("l3_lat_early", 32'(l3_valid), 32'd0);
            if (i == 3) check("l3_lat_first", 32'({l3_valid, l3_addr}), 32'({1'b1, 5'd0}));
        end
        rd_last = cyc_n;
        idle(8);
        check("p1_l1_nvalid", 32'(n1_v), 32'd32);
        check("p1_l1_nskip_nerr", 32'(n1_s + n1_e), 32'd0);
        check("p1_l1_pass", 32'(l1_pass), 32'd32);
        check("p1_l1_err", 32'(l1_errc), 32'd0);
        check("p1_l1_last_valid_t", 32'(t_v1), 32'(rd_last + 1));
        check("p1_l1_round_done_t", 32'(t_rd1), 32'(rd_last + 3));
        check("p1_l1_round", 32'({n1_rd[3:0], ok1}), 32'({4'd1, 1'b1}));
        check("p1_l1_round_cnt", 32'(l1_rcnt), 32'd1);
        check("p1_l3_nvalid", 32'(n3_v), 32'd32);
        check("p1_l3_pass", 32'(l3_pass), 32'd32);
        check("p1_l3_last_valid_t", 32'(t_v3), 32'(rd_last + 3));
        check("p1_l3_round_done_t", 32'(t_rd3), 32'(rd_last + 5));
        check("p1_c4_pass_sat", 32'(c4_pass), 32'hF);
        check("p1_c4_round_cnt", 32'(c4_rcnt), 32'd1);

        // Corrupted read of address 5
        rst_pulse();
        corrupt_en = 1'b1; corrupt_addr = 5'd5;
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 5'(i), 8'(i + 1));
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0, 5'(i), 8'd0);
        idle(8);
        corrupt_en = 1'b0;
        check("p2_l1_nerr", 32'(n1_e), 32'd1);
        check("p2_l1_err_addr", 32'(err_addr1), 32'd5);
        check("p2_l1_err_cnt", 32'(l1_errc), 32'd1);
        check("p2_l1_pass", 32'(l1_pass), 32'd31);
        check("p2_l1_round", 32'({n1_rd[3:0], ok1}), 32'({4'd1, 1'b0}));
        check("p2_l1_round_cnt", 32'(l1_rcnt), 32'd1);
`ifdef RAM_CHK_FIRST_ERR_EN
        check("p2_fe_addr", 32'(l1_fe_addr), 32'd5);
        check("p2_fe_exp", 32'(l1_fe_exp), 32'h06);
        check("p2_fe_act", 32'(l1_fe_act), 32'hFF);
        check("p2_fe_vld", 32'(l1_fe_vld), 32'd1);
`endif

        // Reads of never-written addresses after reset
        rst_pulse();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 5'(i), 8'd0);
        idle(8);
        check("p3_l1_nvalid", 32'(n1_v), 32'd4);
        check("p3_l1_nskip", 32'(n1_s), 32'd4);
        check("p3_l1_nerr", 32'(n1_e), 32'd0);
        check("p3_l1_cnts", 32'({l1_pass, l1_errc}), 32'd0);
`ifdef RAM_CHK_FIRST_ERR_EN
        check("p3_fe_vld", 32'(l1_fe_vld), 32'd0);
`endif

        // RD_LAT=3: read burst followed immediately by a write
        rst_pulse();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 5'(i), 8'(8'h10 + i));
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 5'(i), 8'd0);
        rd_last = cyc_n;
        cyc(1'b1, 1'b1, 5'd9, 8'h55);
        idle(8);
        check("p4_l3_nvalid", 32'(n3_v), 32'd8);
        check("p4_l3_pass", 32'(l3_pass), 32'd8);
        check("p4_l3_last_valid_t", 32'(t_v3), 32'(rd_last + 3));
        check("p4_l3_round_done_t", 32'(t_rd3), 32'(rd_last + 5));
        check("p4_l3_round", 32'({n3_rd[3:0], ok3}), 32'({4'd1, 1'b1}));

        // A read arriving during DRAIN continues the round
        clr();
        cyc(1'b1, 1'b0, 5'd0, 8'd0);
        cyc(1'b0, 1'b0, 5'd0, 8'd0);
        cyc(1'b1, 1'b0, 5'd1, 8'd0);
        rd_last = cyc_n;
        idle(8);
        check("p4b_l1_nround", 32'(n1_rd), 32'd1);
        check("p4b_l1_round_done_t", 32'(t_rd1), 32'(rd_last + 3));
        check("p4b_l3_nround", 32'(n3_rd), 32'd1);
        check("p4b_l1_round_cnt", 32'(l1_rcnt), 32'd2);

        // Reset two cycles into a read burst
        rst_pulse();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 5'(i), 8'(8'h20 + i));
        cyc(1'b1, 1'b0, 5'd0, 8'd0);
        cyc(1'b1, 1'b0, 5'd1, 8'd0);
        rst_pulse();
        idle(8);
        check("p5_nvalid", 32'(n1_v + n3_v), 32'd0);
        check("p5_nround", 32'(n1_rd + n3_rd), 32'd0);
        check("p5_l1_cnts", 32'({l1_pass, l1_errc}), 32'd0);
        check("p5_l3_cnts", 32'({l3_pass, l3_errc}), 32'd0);
        check("p5_round_cnt", 32'({l1_rcnt, l3_rcnt}), 32'd0);

        // 20 mismatches: 4-bit error counter saturates
        rst_pulse();
        corrupt_all = 1'b1;
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 5'(i), 8'(i + 1));
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 5'(i), 8'd0);
        idle(8);
        corrupt_all = 1'b0;
        check("p6_c4_err_sat", 32'(c4_errc), 32'hF);
        check("p6_c4_pass", 32'(c4_pass), 32'd0);
        check("p6_l1_err_cnt", 32'(l1_errc), 32'd20);
        check("p6_l1_nerr", 32'(n1_e), 32'd20);
        check("p6_l1_round", 32'({n1_rd[3:0], ok1}), 32'({4'd1, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
